// File: rtl/dsp48_counter_slice.sv
// dsp48_counter_slice: behavioural DSP48E1 post-adder, P register and
// masked pattern detector, used as a programmable terminal counter.
//
// Ports:
//   fast_clk_i     sole clock, rising edge
//   fast_rst_n_i   asynchronous active-low reset
//   C              48-bit C operand / pattern or mask source
//   CEC, RSTC      C register enable / sync reset (RSTC wins)
//   OPMODE         {Z[6:4], Y[3:2], X[1:0]} operand selects
//   ALUMODE        0011 = Z-(X+Y+CIN), anything else = Z+X+Y+CIN
//   CARRYIN        carry into the adder
//   CEP, RSTP      P/detect enable / sync reset (RSTP wins)
//   P              48-bit P register
//   PATTERNDETECT  registered masked match of P against the pattern
//   PATTERNBDETECT registered masked match against ~pattern
//                  (only with DSP_SLICE_PATB_EN defined)
//
// Optional feature macro: DSP_SLICE_PATB_EN adds PATTERNBDETECT and
// the AUTORESET_PATDET = "RESET_MATCHB" option.

module dsp48_counter_slice #(
    parameter int unsigned CREG               = 1,
    parameter logic [47:0] MASK               = 48'h3FFF_FFFF_FFFF,
    parameter logic [47:0] PATTERN            = 48'h0,
    parameter string       SEL_PATTERN        = "PATTERN",
    parameter string       SEL_MASK           = "MASK",
    parameter string       USE_PATTERN_DETECT = "NO_PATDET",
    parameter string       AUTORESET_PATDET   = "NO_RESET"
) (
    input  logic        fast_clk_i,
    input  logic        fast_rst_n_i,
    input  logic [47:0] C,
    input  logic        CEC,
    input  logic        RSTC,
    input  logic [6:0]  OPMODE,
    input  logic [3:0]  ALUMODE,
    input  logic        CARRYIN,
    input  logic        CEP,
    input  logic        RSTP,
    output logic [47:0] P,
    output logic        PATTERNDETECT
`ifdef DSP_SLICE_PATB_EN
    ,
    output logic        PATTERNBDETECT
`endif
);

    localparam bit PAT_FROM_C = (SEL_PATTERN == "C");
    localparam bit MSK_FROM_C = (SEL_MASK == "C");
    localparam bit PD_EN      = (USE_PATTERN_DETECT == "PATDET");
    localparam bit AR_MATCH   = (AUTORESET_PATDET == "RESET_MATCH");
    localparam bit AR_NMATCH  = (AUTORESET_PATDET == "RESET_NOT_MATCH");
`ifdef DSP_SLICE_PATB_EN
    localparam bit AR_MATCHB  = (AUTORESET_PATDET == "RESET_MATCHB");
`endif

    logic [47:0] c_r;
    logic [47:0] cpath;
    logic [47:0] x_mux;
    logic [47:0] y_mux;
    logic [47:0] z_mux;
    logic [47:0] xyc;
    logic [47:0] alu;
    logic [47:0] pat;
    logic [47:0] msk;
    logic        match;
    logic        pd_past;
    logic        auto_rst;

    // C register; with CREG=0 it is left unused and trimmed.
    always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
        if (!fast_rst_n_i) begin
            c_r <= '0;
        end else if (RSTC) begin
            c_r <= '0;
        end else if (CEC) begin
            c_r <= C;
        end
    end

    assign cpath = (CREG != 0) ? c_r : C;

    always_comb begin
        x_mux = '0;
        y_mux = '0;
        z_mux = '0;
        case (OPMODE[1:0])
            2'b10:   x_mux = P;
            default: x_mux = '0;
        endcase
        case (OPMODE[3:2])
            2'b11:   y_mux = cpath;
            default: y_mux = '0;
        endcase
        case (OPMODE[6:4])
            3'b010:  z_mux = P;
            3'b011:  z_mux = cpath;
            default: z_mux = '0;
        endcase
    end

    assign xyc = x_mux + y_mux + {47'b0, CARRYIN};

    // Only subtract is decoded; every other ALUMODE adds.
    assign alu = (ALUMODE == 4'b0011) ? (z_mux - xyc) : (z_mux + xyc);

    assign pat   = PAT_FROM_C ? cpath : PATTERN;
    assign msk   = MSK_FROM_C ? cpath : MASK;
    assign match = (((alu ^ pat) & ~msk) == '0);

`ifdef DSP_SLICE_PATB_EN
    logic matchb;

    assign matchb = (((alu ^ ~pat) & ~msk) == '0);
`endif

    // Auto-reset looks at the registered flags, so the terminal value
    // is visible on P for exactly one cycle before the rewind.
    always_comb begin
        auto_rst = 1'b0;
        if (AR_MATCH && PATTERNDETECT) begin
            auto_rst = 1'b1;
        end
        if (AR_NMATCH && !PATTERNDETECT && pd_past) begin
            auto_rst = 1'b1;
        end
`ifdef DSP_SLICE_PATB_EN
        if (AR_MATCHB && PATTERNBDETECT) begin
            auto_rst = 1'b1;
        end
`endif
    end

    always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
        if (!fast_rst_n_i) begin
            P             <= '0;
            PATTERNDETECT <= 1'b0;
            pd_past       <= 1'b0;
        end else if (RSTP || auto_rst) begin
            P             <= '0;
            PATTERNDETECT <= 1'b0;
            pd_past       <= 1'b0;
        end else begin
            // pd_past tracks the flag every cycle so a falling edge
            // is seen even while CEP holds the register.
            pd_past <= PATTERNDETECT;
            if (CEP) begin
                P             <= alu;
                PATTERNDETECT <= PD_EN ? match : 1'b0;
            end
        end
    end

`ifdef DSP_SLICE_PATB_EN
    always_ff @(posedge fast_clk_i or negedge fast_rst_n_i) begin
        if (!fast_rst_n_i) begin
            PATTERNBDETECT <= 1'b0;
        end else if (RSTP || auto_rst) begin
            PATTERNBDETECT <= 1'b0;
        end else if (CEP) begin
            PATTERNBDETECT <= PD_EN ? matchb : 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_dsp48_counter_slice.sv
// tb_dsp48_counter_slice: directed vector bench for dsp48_counter_slice.
// One counter-configured instance and one arithmetic-configured instance.

module tb_dsp48_counter_slice;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // counter instance
    logic [47:0] c_c = '0;
    logic        c_cec = 1'b0;
    logic        c_rstc = 1'b0;
    logic        c_cin = 1'b1;
    logic        c_cep = 1'b0;
    logic        c_rstp = 1'b0;
    logic [47:0] c_p;
    logic        c_pd;

    // arithmetic instance
    logic [47:0] a_c = '0;
    logic [6:0]  a_op = '0;
    logic [3:0]  a_alu = '0;
    logic        a_cin = 1'b0;
    logic        a_cep = 1'b0;
    logic        a_rstp = 1'b0;
    logic [47:0] a_p;
    logic        a_pd;

`ifdef DSP_SLICE_PATB_EN
    logic c_pbd;
    logic a_pbd;
`endif

    dsp48_counter_slice #(
        .CREG(1),
        .MASK(48'hFFFF_FFFF_0000),
        .PATTERN(48'h0),
        .SEL_PATTERN("C"),
        .SEL_MASK("MASK"),
        .USE_PATTERN_DETECT("PATDET"),
        .AUTORESET_PATDET("RESET_MATCH")
    ) u_cnt (
        .fast_clk_i(clk),
        .fast_rst_n_i(rst_n),
        .C(c_c),
        .CEC(c_cec),
        .RSTC(c_rstc),
        .OPMODE(7'b0100000),
        .ALUMODE(4'b0000),
        .CARRYIN(c_cin),
        .CEP(c_cep),
        .RSTP(c_rstp),
        .P(c_p),
        .PATTERNDETECT(c_pd)
`ifdef DSP_SLICE_PATB_EN
        ,
        .PATTERNBDETECT(c_pbd)
`endif
    );

    dsp48_counter_slice #(
        .CREG(0),
        .USE_PATTERN_DETECT("NO_PATDET"),
        .AUTORESET_PATDET("NO_RESET")
    ) u_arith (
        .fast_clk_i(clk),
        .fast_rst_n_i(rst_n),
        .C(a_c),
        .CEC(1'b0),
        .RSTC(1'b0),
        .OPMODE(a_op),
        .ALUMODE(a_alu),
        .CARRYIN(a_cin),
        .CEP(a_cep),
        .RSTP(a_rstp),
        .P(a_p),
        .PATTERNDETECT(a_pd)
`ifdef DSP_SLICE_PATB_EN
        ,
        .PATTERNBDETECT(a_pbd)
`endif
    );

    typedef struct {
        logic [47:0] c;
        logic        cec;
        logic        rstc;
        logic        cep;
        logic        rstp;
        logic        cin;
        logic [47:0] p;
        logic        pd;
    } cvec_t;

    typedef struct {
        logic [6:0]  op;
        logic [3:0]  alu;
        logic        cin;
        logic [47:0] c;
        logic        cep;
        logic        rstp;
        logic [47:0] p;
    } avec_t;

    cvec_t cv[$];
    avec_t av[$];

    int checks = 0;
    int errors = 0;

    task automatic chk48(input string name, input logic [47:0] act,
                         input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act,
                        input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic addc(input logic [47:0] c, input logic cec,
                        input logic rstc, input logic cep,
                        input logic rstp, input logic cin,
                        input logic [47:0] p, input logic pd);
        cvec_t v;
        v.c = c; v.cec = cec; v.rstc = rstc; v.cep = cep;
        v.rstp = rstp; v.cin = cin; v.p = p; v.pd = pd;
        cv.push_back(v);
    endtask

    task automatic adda(input logic [6:0] op, input logic [3:0] alu,
                        input logic cin, input logic [47:0] c,
                        input logic cep, input logic rstp,
                        input logic [47:0] p);
        avec_t v;
        v.op = op; v.alu = alu; v.cin = cin; v.c = c;
        v.cep = cep; v.rstp = rstp; v.p = p;
        av.push_back(v);
    endtask

    task automatic cnt_edge(input logic [47:0] c, input logic cec,
                            input logic cep, input logic rstp);
        @(negedge clk);
        c_c = c; c_cec = cec; c_rstc = 1'b0;
        c_cep = cep; c_rstp = rstp; c_cin = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // counter: c cec rstc cep rstp cin -> P PD
        // terminal 5: load with RSTP, then count and rewind
        addc(48'd5, 1, 0, 0, 1, 1, 48'd0, 0);
        for (int k = 0; k < 2; k++) begin
            addc(0, 0, 0, 1, 0, 1, 48'd1, 0);
            addc(0, 0, 0, 1, 0, 1, 48'd2, 0);
            addc(0, 0, 0, 1, 0, 1, 48'd3, 0);
            addc(0, 0, 0, 1, 0, 1, 48'd4, 0);
            addc(0, 0, 0, 1, 0, 1, 48'd5, 1);
            addc(0, 0, 0, 1, 0, 1, 48'd0, 0);
        end
        // CEP gating; auto-reset fires with CEP low
        addc(0, 0, 0, 0, 0, 1, 48'd0, 0);
        for (int k = 1; k <= 4; k++) begin
            addc(0, 0, 0, 1, 0, 1, 48'(k), 0);
            addc(0, 0, 0, 0, 0, 1, 48'(k), 0);
        end
        addc(0, 0, 0, 1, 0, 1, 48'd5, 1);
        addc(0, 0, 0, 0, 0, 1, 48'd0, 0);
        // masked upper bits: terminal at 3
        addc(48'h0001_0003, 1, 0, 0, 0, 1, 48'd0, 0);
        addc(0, 0, 0, 1, 0, 1, 48'd1, 0);
        addc(0, 0, 0, 1, 0, 1, 48'd2, 0);
        addc(0, 0, 0, 1, 0, 1, 48'd3, 1);
        addc(0, 0, 0, 1, 0, 1, 48'd0, 0);
        // C load compares against old C_r on the load edge
        addc(48'd1, 1, 0, 1, 0, 1, 48'd1, 0);
        addc(0, 0, 0, 1, 1, 1, 48'd0, 0);
        addc(0, 0, 0, 1, 0, 1, 48'd1, 1);
        addc(0, 0, 0, 1, 0, 1, 48'd0, 0);
        // RSTP beats CEP at P=2
        addc(48'd5, 1, 0, 0, 0, 1, 48'd0, 0);
        addc(0, 0, 0, 1, 0, 1, 48'd1, 0);
        addc(0, 0, 0, 1, 0, 1, 48'd2, 0);
        addc(0, 0, 0, 1, 1, 1, 48'd0, 0);
        addc(0, 0, 0, 1, 0, 1, 48'd1, 0);
        // RSTC beats CEC: C_r becomes 0, so alu=0 then matches
        addc(48'd7, 1, 1, 1, 0, 1, 48'd2, 0);
        addc(0, 0, 0, 0, 1, 1, 48'd0, 0);
        addc(0, 0, 0, 1, 0, 0, 48'd0, 1);
        addc(0, 0, 0, 1, 0, 0, 48'd0, 0);
        addc(0, 0, 0, 1, 0, 0, 48'd0, 1);

        // arithmetic: op alu cin c cep rstp -> P
        adda(7'b0110000, 4'b0011, 1, 48'd10, 1, 0, 48'd9);
        adda(7'b0110000, 4'b0000, 1, 48'd10, 1, 0, 48'd11);
        adda(7'b0110000, 4'b0000, 1, 48'd20, 0, 0, 48'd11);
        adda(7'b0110000, 4'b0101, 0, 48'd20, 1, 0, 48'd20);
        adda(7'b0110000, 4'b0000, 0, 48'hFFFF_FFFF_FFFF, 1, 0,
             48'hFFFF_FFFF_FFFF);
        adda(7'b0001110, 4'b0000, 0, 48'd2, 1, 0, 48'd1);
        adda(7'b0001110, 4'b0000, 1, 48'd5, 1, 0, 48'd7);
        adda(7'b0101110, 4'b0000, 0, 48'd1, 1, 0, 48'd15);
        adda(7'b0100010, 4'b0011, 0, 48'd1, 1, 0, 48'd0);
        adda(7'b0001100, 4'b0011, 1, 48'd0, 1, 0,
             48'hFFFF_FFFF_FFFF);
        adda(7'b0110000, 4'b0000, 0, 48'd100, 1, 0, 48'd100);
        adda(7'b0010101, 4'b0000, 0, 48'd3, 1, 0, 48'd0);
        adda(7'b0110000, 4'b0000, 0, 48'd100, 1, 0, 48'd100);
        adda(7'b0101100, 4'b0011, 1, 48'd30, 1, 0, 48'd69);
        adda(7'b0101000, 4'b0000, 0, 48'd30, 1, 0, 48'd69);
        adda(7'b0110000, 4'b0000, 0, 48'd30, 0, 1, 48'd0);
        adda(7'b0110000, 4'b0000, 0, 48'd30, 1, 0, 48'd30);
        adda(7'b1001011, 4'b0000, 0, 48'd30, 1, 0, 48'd0);
        adda(7'b0110000, 4'b0000, 0, 48'd55, 1, 0, 48'd55);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk48("rst cnt P", c_p, 48'd0);
        chk1("rst cnt PD", c_pd, 1'b0);
        chk48("rst arith P", a_p, 48'd0);
        chk1("rst arith PD", a_pd, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (cv[i]) begin
            @(negedge clk);
            c_c = cv[i].c; c_cec = cv[i].cec; c_rstc = cv[i].rstc;
            c_cep = cv[i].cep; c_rstp = cv[i].rstp; c_cin = cv[i].cin;
            @(posedge clk);
            #1;
            chk48($sformatf("cnt[%0d] P", i), c_p, cv[i].p);
            chk1($sformatf("cnt[%0d] PD", i), c_pd, cv[i].pd);
        end

        @(negedge clk);
        c_cec = 1'b0; c_rstc = 1'b0; c_cep = 1'b0; c_rstp = 1'b1;

        foreach (av[i]) begin
            @(negedge clk);
            a_op = av[i].op; a_alu = av[i].alu; a_cin = av[i].cin;
            a_c = av[i].c; a_cep = av[i].cep; a_rstp = av[i].rstp;
            @(posedge clk);
            #1;
            chk48($sformatf("arith[%0d] P", i), a_p, av[i].p);
            chk1($sformatf("arith[%0d] PD", i), a_pd, 1'b0);
        end

        // async reset mid-count at P=4
        cnt_edge(48'd5, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cnt_edge(48'd0, 1'b0, 1'b1, 1'b0);
        end
        chk48("pre-arst cnt P", c_p, 48'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk48("arst cnt P", c_p, 48'd0);
        chk1("arst cnt PD", c_pd, 1'b0);
        chk48("arst arith P", a_p, 48'd0);
        @(posedge clk);
        #1;
        chk48("arst held cnt P", c_p, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk48("post-arst cnt P1", c_p, 48'd1);
        chk1("post-arst cnt PD1", c_pd, 1'b0);
        @(posedge clk);
        #1;
        chk48("post-arst cnt P2", c_p, 48'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp48_counter_slice.md
Name: dsp48_counter_slice

Overview:
- Behavioural, synthesizable subset of the DSP48E1 post-adder/P-register/pattern-detector path.
- Used as a programmable terminal counter: P accumulates by the carry-in, C holds the terminal value, the masked pattern detector flags the match, and auto-reset rewinds P.
- Replaces the hard primitive in simulation and portable builds; the multiplier, A, B and D paths are out of scope.

Parameters:
- CREG, 1, 1 = C input registered (CEC/RSTC apply); 0 = C combinational.
- MASK, 48'h3FFF_FFFF_FFFF, bit=1 ignores that bit in the pattern compare.
- PATTERN, 48'h0, constant pattern used when SEL_PATTERN="PATTERN".
- SEL_PATTERN, "PATTERN", "PATTERN" or "C" (use the C-path value as the pattern).
- SEL_MASK, "MASK", "MASK" or "C" (use the C-path value as the mask).
- USE_PATTERN_DETECT, "NO_PATDET", "PATDET" enables the detector; otherwise detect outputs are held 0.
- AUTORESET_PATDET, "NO_RESET", "NO_RESET" | "RESET_MATCH" | "RESET_NOT_MATCH".

Ports:
- fast_clk_i, in, 1, sole clock, rising edge.
- fast_rst_n_i, in, 1, asynchronous active-low reset.
- C, in, 48, C operand / pattern source.
- CEC, in, 1, C register clock enable.
- RSTC, in, 1, synchronous C register reset, priority over CEC.
- OPMODE, in, 7, {Z[6:4], Y[3:2], X[1:0]}.
- ALUMODE, in, 4, adder function.
- CARRYIN, in, 1, carry into the adder.
- CEP, in, 1, P and detect register enable.
- RSTP, in, 1, synchronous P/detect reset, priority over CEP.
- P, out, 48, P register.
- PATTERNDETECT, out, 1, registered masked match of P against the pattern.

Behaviour:
- Async reset (fast_rst_n_i=0): C reg, P, PATTERNDETECT (and PATTERNBDETECT) = 0 immediately; held while low.
- C path: if CREG=1, C_r <= 0 on RSTC, else C on CEC, else hold. cpath = C_r (CREG=1) or C (CREG=0).
- X mux: 00 -> 0; 10 -> P; other codes -> 0.
- Y mux: 00 -> 0; 11 -> cpath; other codes -> 0.
- Z mux: 000 -> 0; 010 -> P; 011 -> cpath; other codes -> 0.
- ALUMODE 0000: alu = Z+X+Y+CARRYIN. ALUMODE 0011: alu = Z-(X+Y+CARRYIN). Any other code behaves as 0000.
- All arithmetic is 48-bit modulo 2^48; carry-out and overflow are discarded.
- pat = cpath if SEL_PATTERN="C", else PATTERN. msk = cpath if SEL_MASK="C", else MASK.
- match = ((alu ^ pat) & ~msk) == 0.
- auto_rst is 1 when:
  - AUTORESET_PATDET="RESET_MATCH" and PATTERNDETECT=1; or
  - AUTORESET_PATDET="RESET_NOT_MATCH" and PATTERNDETECT=0 and the previous-cycle PATTERNDETECT was 1.
- Each rising edge:
  - if RSTP or auto_rst: P <= 0, detect regs <= 0 (regardless of CEP);
  - else if CEP: P <= alu, PATTERNDETECT <= match (when USE_PATTERN_DETECT="PATDET", else 0);
  - else hold.
- Latency: a PATTERNDETECT rise is coincident with the P value that matched. With RESET_MATCH, P reads 0 exactly one edge later, so the terminal value lasts exactly one cycle.
- Simultaneous events: RSTP wins over CEP. Auto-reset wins over CEP. RSTC wins over CEC. An async reset overrides everything.
- The compare uses the current cpath value, so a C load lands on the first edge after CEC=1. The detect compares against the new C_r from the following edge onward.

Optional Feature:
- Macro: DSP_SLICE_PATB_EN.
- Defined:
  - adds output PATTERNBDETECT (1 bit), registered exactly like PATTERNDETECT but with matchb = ((alu ^ ~pat) & ~msk) == 0;
  - AUTORESET_PATDET additionally accepts "RESET_MATCHB", which auto-resets on PATTERNBDETECT=1.
- Not defined: the port and the "RESET_MATCHB" option are absent; logic is identical otherwise.

Test Plan:
1. Counter: CREG=1, SEL_PATTERN="C", MASK=48'hFFFF_FFFF_0000, USE_PATTERN_DETECT="PATDET", AUTORESET_PATDET="RESET_MATCH", OPMODE=7'b0100000, ALUMODE=0, CARRYIN=1. Pulse CEC+RSTP with C=5, then hold CEP=1 -> P steps 1,2,3,4,5 with PATTERNDETECT=1 only at P=5, then P=0, and it repeats every 6 cycles.
2. CEP gating: same setup, CEP toggled 1/0 -> P advances only on CEP=1 edges; the match still pulses for one cycle at P=5 and auto-resets even when CEP=0.
3. Mask: same counter with C=48'h0001_0003 -> detect fires at P=3 because the upper-bit difference is masked.
4. Priority: assert RSTP and CEP together at P=2 -> P=0, PATTERNDETECT=0. RSTC with CEC -> C_r=0.
5. Async reset: drop fast_rst_n_i mid-count at P=4 -> P=0 and PATTERNDETECT=0 before the next edge; counting resumes from 0 after release.
6. Arithmetic: OPMODE Z=C, Y=0, X=0, ALUMODE=0011, C=10, CARRYIN=1, CEP=1 -> P=9. With ALUMODE=0000 -> P=11. With X=P accumulating, P wraps modulo 2^48.
